// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised sync_fifo: default sizes and the
// helper that derives pointer/count widths from the depth.
package sync_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  function automatic int unsigned clog2_depth(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake bundle between the FIFO (slave) and its producer/consumer (master).
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  localparam int unsigned CW = clog2_depth(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and a registered,
// enabled read port. Only the read register is reset; the array is not.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address returns the old word, which is what
  // a simultaneous read+write at full requires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with count, threshold flags and registered read.
// Optional sticky overflow/underflow capture enabled by SYNC_FIFO_STICKY_ERR_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  sync_fifo_if.slave  bus
);

  localparam int unsigned   AW     = clog2_depth(DEPTH);
  localparam int unsigned   CW     = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [CW-1:0]    wr_ptr, rd_ptr, cnt, cnt_next;
  logic             full_q, empty_q, af_q, ae_q, valid_q;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] rdata;

  // A read frees a slot in the same edge, so a write at full is still taken.
  always_comb begin
    rd_ok    = bus.rd_en && !empty_q;
    wr_ok    = bus.wr_en && (!full_q || rd_ok);
    cnt_next = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + CW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + CW'(1);
      cnt     <= cnt_next;
      full_q  <= (cnt_next == FULL_C);
      empty_q <= (cnt_next == '0);
      af_q    <= (cnt_next >= AF_C);
      ae_q    <= (cnt_next <= AE_C);
      valid_q <= rd_ok;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   (bus.data_in),
    .re      (rd_ok),
    .raddr   (rd_ptr[AW-1:0]),
    .rdata   (rdata)
  );

  assign bus.data_out     = rdata;
  assign bus.data_valid   = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;

`ifdef SYNC_FIFO_STICKY_ERR_EN
  logic ovf_q, unf_q;

  // Set takes priority over err_clr in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_q && !rd_ok) ovf_q <= 1'b1;
      else if (bus.err_clr)              ovf_q <= 1'b0;
      if (bus.rd_en && empty_q)          unf_q <= 1'b1;
      else if (bus.err_clr)              unf_q <= 1'b0;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
